// File: rtl/mulfold_for_1483.sv
// Two-stage multiply-and-fold front end for the GF(1483) Barrett reducer.
// Optional operand range flag compiled in with MULFOLD1483_RANGE_CHK_EN.
module mulfold_for_1483 #(
  parameter int Q      = 1483,
  parameter int K      = 11,
  parameter int FOLD_C = 1518592,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K-1:0]       in_a,
  input  logic [K-1:0]       in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*K-2:0]     out_din_a,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int PW = 2 * K;
  localparam int FW = 2 * K - 1;
  localparam logic [PW-1:0] FOLD_P = PW'(FOLD_C);

  // The fold constant must be a multiple of Q or the folded value loses congruence.
  if (FOLD_C != Q * 1024) begin : g_bad_fold_c
    $error("FOLD_C must equal Q*2^10");
  end

  logic              s1_valid;
  logic [PW-1:0]     s1_p;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_valid;
  logic [FW-1:0]     s2_f;
  logic [TAG_W-1:0]  s2_tag;

  logic              adv1;
  logic              adv2;
  logic [PW-1:0]     prod;
  logic [FW-1:0]     fold_f;

  // A stage may load when it is empty or its content leaves this cycle.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  assign prod = PW'(in_a) * PW'(in_b);

  // Single conditional subtract; out-of-range products simply truncate.
  always_comb begin
    fold_f = FW'(s1_p);
    if (s1_p >= FOLD_P) begin
      fold_f = FW'(s1_p - FOLD_P);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  // NOTE: data registers are reset too, so out_din_a/out_tag read 0 the
  // moment rst_n falls instead of showing stale beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_f     <= '0;
      s2_tag   <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_f   <= fold_f;
          s2_tag <= s1_tag;
        end
      end
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_p   <= prod;
          s1_tag <= in_tag;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_din_a = s2_f;
  assign out_tag   = s2_tag;

`ifdef MULFOLD1483_RANGE_CHK_EN
  localparam logic [K-1:0] Q_K = K'(Q);

  logic in_err;
  logic s1_err;
  logic s2_err;

  assign in_err = (in_a >= Q_K) || (in_b >= Q_K);

  // The error flag follows exactly the same load enables as its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err <= 1'b0;
      s2_err <= 1'b0;
    end else begin
      if (adv2 && s1_valid) begin
        s2_err <= s1_err;
      end
      if (adv1 && in_valid) begin
        s1_err <= in_err;
      end
    end
  end

  assign out_err = s2_err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mulfold_for_1483.sv
// Directed bench for mulfold_for_1483 with a queue scoreboard; honours
// MULFOLD1483_RANGE_CHK_EN for the expected error flag.
module tb_mulfold_for_1483;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_a = '0;
  logic [10:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] out_din_a;
  logic [3:0]  out_tag;
  logic        out_err;

  mulfold_for_1483 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_din_a (out_din_a),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] din;
    logic [3:0]  tag;
    logic        err;
    logic        in_range;
    int unsigned res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail = 0;
  int   w;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b, input logic [3:0] t);
    exp_t        m;
    int unsigned p;
    p          = a * b;
    m.din      = (p >= 1518592) ? 21'(p - 1518592) : 21'(p);
    m.tag      = t;
    m.in_range = (a < 1483) && (b < 1483);
`ifdef MULFOLD1483_RANGE_CHK_EN
    m.err      = !m.in_range;
`else
    m.err      = 1'b0;
`endif
    m.res      = p % 1483;
    return m;
  endfunction

  // Output side: every accepted output beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_din_a", out_din_a, mon_e.din);
        check("out_tag", out_tag, mon_e.tag);
        check("out_err", out_err, mon_e.err);
        if (mon_e.in_range) check("residue", out_din_a % 1483, mon_e.res);
      end
    end
  end

  task automatic send(input int unsigned a, input int unsigned b, input logic [3:0] t,
                      output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_a     = 11'(a);
    in_b     = 11'(b);
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("in_accept", in_ready, 1);
    sb.push_back(model(a, b, t));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_din_a", out_din_a, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single beat: largest in-range product, checks latency of two edges.
    send(1482, 1482, 4'd3, w);
    @(negedge clk);
    check("lat1_out_valid", out_valid, 0);
    @(negedge clk);
    check("lat2_out_valid", out_valid, 1);
    check("lat2_din", out_din_a, 677732);
    check("lat2_tag", out_tag, 3);
    check("lat2_reduced", out_din_a % 1483, 1);
    drain();

    // No-fold and zero beats.
    send(1000, 1000, 4'd5, w);
    send(0, 1234, 4'd6, w);
    drain();

    // Back-to-back stream: in_ready must never drop with out_ready high.
    for (int i = 0; i < 8; i++) begin
      send(i, 1482 - i, 4'(i), w);
      check("stream_no_stall", w, 0);
    end
    drain();

    // Stall: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(11, 13, 4'd1, w);
    send(1400, 1300, 4'd2, w);
    in_valid = 1'b1;
    in_a     = 11'd17;
    in_b     = 11'd19;
    in_tag   = 4'd4;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_din", out_din_a, 143);
    check("stall_tag", out_tag, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_in_ready_hold", in_ready, 0);
    check("stall_din_hold", out_din_a, 143);
    check("stall_tag_hold", out_tag, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("full_shift_in_ready", in_ready, 1);
    sb.push_back(model(17, 19, 4'd4));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Out-of-range operand followed by a normal beat.
    send(1483, 1, 4'd9, w);
    send(5, 7, 4'd10, w);
    drain();

    // Asynchronous reset between edges with a full pipe.
    out_ready = 1'b0;
    send(100, 200, 4'd7, w);
    send(300, 400, 4'd8, w);
    @(posedge clk);
    #3;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_din", out_din_a, 0);
    check("async_rst_tag", out_tag, 0);
    check("async_rst_in_ready", in_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    send(21, 22, 4'd12, w);
    @(negedge clk);
    check("post_rst_lat1", out_valid, 0);
    @(negedge clk);
    check("post_rst_lat2", out_valid, 1);
    check("post_rst_din", out_din_a, 462);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
